// File: rtl/ps2_scancode_rx_pkg.sv
// Shared scan-code constants, drop list and frame FSM state
// encoding for the PS/2 receive path.
package ps2_scancode_rx_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   // Keyboard status/response bytes that never form a key event
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT_OK = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_BAT_NG = 8'hFC;
   localparam logic [7:0] SC_OVR_0  = 8'h00;
   localparam logic [7:0] SC_OVR_F  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_st_e;

   function automatic logic is_drop(input logic [7:0] b);
      return (b == SC_PAUSE)  || (b == SC_BAT_OK) ||
             (b == SC_ACK)    || (b == SC_ECHO)   ||
             (b == SC_BAT_NG) || (b == SC_OVR_0)  ||
             (b == SC_OVR_F);
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the raw lines,
// deserialises 11-bit frames and flags parity/stop/timeout errors.
// Ports: clk_i, rst_i (sync, active high), ps2_clk_i, ps2_data_i
// (raw, async), byte_o + byte_rdy_o (good byte pulse), frame_err_o.
module ps2_frame_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_rdy_o,
   output logic       frame_err_o
);

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

   logic [1:0]    clk_sync_q;
   logic [1:0]    dat_sync_q;
   logic          clk_s;
   logic          dat_s;
   logic          clk_filt_q;
   logic [FW-1:0] filt_cnt_q;
   logic          fall_q;

   frame_st_e     state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shreg_q;
   logic          par_q;
   logic [TW-1:0] to_cnt_q;
   logic [7:0]    byte_q;
   logic          byte_rdy_q;
   logic          frame_err_q;

   assign clk_s = clk_sync_q[1];
   assign dat_s = dat_sync_q[1];

   // Lines idle high, so the synchroniser and filter reset high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      end
   end

   // Level moves only on the FILT_LEN-th consecutive differing sample
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
         fall_q     <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (clk_s == clk_filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FILT_MAX) begin
            clk_filt_q <= clk_s;
            filt_cnt_q <= '0;
            fall_q     <= ~clk_s;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (rst_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
         byte_q    <= '0;
      end else if (state_q != ST_IDLE && !fall_q &&
                   to_cnt_q == TO_MAX) begin
         state_q     <= ST_IDLE;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b1;
      end else begin
         if (fall_q || state_q == ST_IDLE)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + 1'b1;
         if (fall_q) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!dat_s) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shreg_q[bit_cnt_q] <= dat_s;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7)
                     state_q <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_q   <= dat_s;
                  state_q <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  // Odd parity: data plus parity holds an odd count of ones
                  if (dat_s && (^{shreg_q, par_q})) begin
                     byte_q     <= shreg_q;
                     byte_rdy_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign byte_o      = byte_q;
   assign byte_rdy_o  = byte_rdy_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 scan-code receiver: frames bytes, folds E0/F0 prefixes into
// one event per key and tracks shift. Ports: clk, rst, ps2_clk_in,
// ps2_data_in in; key_valid/key_code/key_break/key_ext, shift_held,
// frame_err out.
module ps2_scancode_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_break,
   output logic       key_ext,
   output logic       shift_held,
   output logic       frame_err
);

   logic [7:0] byte_w;
   logic       byte_rdy_w;

   logic       key_valid_q;
   logic [7:0] key_code_q;
   logic       key_break_q;
   logic       key_ext_q;
   logic       ext_pend_q;
   logic       brk_pend_q;
   logic       lshift_q;
   logic       rshift_q;

   ps2_frame_rx #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame (
      .clk_i       (clk),
      .rst_i       (rst),
      .ps2_clk_i   (ps2_clk_in),
      .ps2_data_i  (ps2_data_in),
      .byte_o      (byte_w),
      .byte_rdy_o  (byte_rdy_w),
      .frame_err_o (frame_err)
   );

   always_ff @(posedge clk) begin
      key_valid_q <= 1'b0;
      if (rst) begin
         key_code_q  <= '0;
         key_break_q <= 1'b0;
         key_ext_q   <= 1'b0;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
      end else if (byte_rdy_w) begin
         if (byte_w == SC_EXT) begin
            ext_pend_q <= 1'b1;
         end else if (byte_w == SC_BRK) begin
            brk_pend_q <= 1'b1;
         end else if (!is_drop(byte_w)) begin
            key_valid_q <= 1'b1;
            key_code_q  <= byte_w;
            key_break_q <= brk_pend_q;
            key_ext_q   <= ext_pend_q;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            // E0 12 is print-screen's fake shift, not a real one
            if (!ext_pend_q && byte_w == SC_LSHIFT)
               lshift_q <= ~brk_pend_q;
            if (!ext_pend_q && byte_w == SC_RSHIFT)
               rshift_q <= ~brk_pend_q;
         end
      end
   end

   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign key_break  = key_break_q;
   assign key_ext    = key_ext_q;
   assign shift_held = lshift_q | rshift_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames with
// hand-computed events, checked by a separate monitor.
module tb_ps2_scancode_rx;

   localparam int FILT = 4;
   localparam int TO   = 1000;
   localparam int H    = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_break;
   logic       key_ext;
   logic       shift_held;
   logic       frame_err;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic       sh;
   } ev_t;

   ev_t  exp_q[$];
   bit   err_q[$];
   int   rst_req = 0;
   int   rst_done = 0;
   bit   end_req = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ps2_scancode_rx #(
      .FILT_LEN    (FILT),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk),
      .ps2_data_in (ps2_data),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_break   (key_break),
      .key_ext     (key_ext),
      .shift_held  (shift_held),
      .frame_err   (frame_err)
   );

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      tick(H / 2);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
      tick(H / 2);
   endtask

   task automatic send(input logic [7:0] b, input logic pflip);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++)
         ps2_bit(b[i]);
      ps2_bit(~(^b) ^ pflip);
      ps2_bit(1'b1);
      tick(H);
   endtask

   task automatic expk(input logic [7:0] c, input logic br,
                       input logic ex, input logic sh);
      ev_t e;
      e.code = c;
      e.brk  = br;
      e.ext  = ex;
      e.sh   = sh;
      exp_q.push_back(e);
   endtask

   // Monitor: owns all comparison counters
   initial begin
      int  cyc;
      ev_t e;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_req != rst_done) begin
            rst_done++;
            chk("rst_key_valid", int'(key_valid), 0);
            chk("rst_key_code", int'(key_code), 0);
            chk("rst_key_break", int'(key_break), 0);
            chk("rst_key_ext", int'(key_ext), 0);
            chk("rst_shift", int'(shift_held), 0);
            chk("rst_frame_err", int'(frame_err), 0);
         end
         if (key_valid || frame_err)
            chk("valid_err_overlap", int'(key_valid & frame_err), 0);
         if (key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_key: got code %0h expected none",
                        key_code);
            end else begin
               e = exp_q.pop_front();
               chk("key_code", int'(key_code), int'(e.code));
               chk("key_break", int'(key_break), int'(e.brk));
               chk("key_ext", int'(key_ext), int'(e.ext));
               chk("shift_held", int'(shift_held), int'(e.sh));
            end
         end
         if (frame_err) begin
            checks++;
            if (err_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_err: got 1 expected 0");
            end else begin
               void'(err_q.pop_front());
            end
         end
         if (cyc > 80000) begin
            errors++;
            $display("FAIL watchdog: got %0d cycles expected fewer", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         if (end_req) begin
            chk("keys_missing", exp_q.size(), 0);
            chk("errs_missing", err_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      tick(3);
      rst = 1'b0;
      rst_req++;
      tick(50);

      expk(8'h1C, 1'b0, 1'b0, 1'b0);
      send(8'h1C, 1'b0);

      expk(8'h12, 1'b0, 1'b0, 1'b1);
      send(8'h12, 1'b0);
      expk(8'h1C, 1'b0, 1'b0, 1'b1);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      expk(8'h1C, 1'b1, 1'b0, 1'b1);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      expk(8'h12, 1'b1, 1'b0, 1'b0);
      send(8'h12, 1'b0);

      send(8'hE0, 1'b0);
      expk(8'h75, 1'b0, 1'b1, 1'b0);
      send(8'h75, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      expk(8'h75, 1'b1, 1'b1, 1'b0);
      send(8'h75, 1'b0);

      send(8'hE0, 1'b0);
      expk(8'h12, 1'b0, 1'b1, 1'b0);
      send(8'h12, 1'b0);

      send(8'hE0, 1'b0);
      send(8'hAA, 1'b0);
      expk(8'h75, 1'b0, 1'b1, 1'b0);
      send(8'h75, 1'b0);

      err_q.push_back(1'b1);
      send(8'h1C, 1'b1);
      expk(8'h32, 1'b0, 1'b0, 1'b0);
      send(8'h32, 1'b0);

      send(8'hF0, 1'b0);
      err_q.push_back(1'b1);
      send(8'h1C, 1'b1);
      expk(8'h1C, 1'b1, 1'b0, 1'b0);
      send(8'h1C, 1'b0);

      err_q.push_back(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      tick(TO + 10);
      expk(8'h1C, 1'b0, 1'b0, 1'b0);
      send(8'h1C, 1'b0);

      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(50);
      ps2_bit(1'b1);
      tick(50);

      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      rst_req++;
      tick(50);
      expk(8'h1E, 1'b0, 1'b0, 1'b0);
      send(8'h1E, 1'b0);

      tick(100);
      end_req = 1'b1;
   end

endmodule
